// File: rtl/tone_pkg.sv
// tone_pkg: shared types and the default pattern table for tone_sequencer.
//   pattern_t        - one beep pattern (tone half period, on/off time, repeats)
//   state_t          - sequencer states
//   DEFAULT_PATTERNS - four-entry factory table, entry 0 in the low bits
package tone_pkg;

    typedef struct packed {
        logic [17:0] half_period;  // CLK cycles per half tone period, >= 1
        logic [11:0] on_ms;
        logic [11:0] off_ms;
        logic [3:0]  repeats;
    } pattern_t;

    typedef enum logic [1:0] {
        IDLE,
        TONE,
        GAP,
        FINISH
    } state_t;

    localparam pattern_t [3:0] DEFAULT_PATTERNS = {
        pattern_t'{half_period: 18'd125000, on_ms: 12'd500, off_ms: 12'd250, repeats: 4'd2}, // error
        pattern_t'{half_period: 18'd50000,  on_ms: 12'd100, off_ms: 12'd100, repeats: 4'd3}, // keypress ack
        pattern_t'{half_period: 18'd24414,  on_ms: 12'd50,  off_ms: 12'd50,  repeats: 4'd5}, // alarm
        pattern_t'{half_period: 18'd62500,  on_ms: 12'd200, off_ms: 12'd0,   repeats: 4'd1}  // arm warning
    };

endpackage

// File: rtl/tone_sequencer_ms_ticker.sv
// ms_ticker: free-running prescaler producing a one-cycle tick every TICK_DIV cycles.
//   clk      - system clock
//   reset_n  - synchronous active-low reset
//   clr      - restart the prescaler from 0 on the next edge
//   tick     - high in the last cycle of each TICK_DIV-cycle interval
module ms_ticker #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays one of NUM_PATTERNS beep patterns as a square wave.
//   CLK      - system clock
//   reset_n  - synchronous active-low reset
//   start    - one-cycle request, honoured only in IDLE with an in-range mode
//   mode     - pattern index, latched with start
//   abort    - return to IDLE on the next edge from any active state
//   out      - square-wave tone, 0 outside TONE
//   busy     - high while a pattern is playing (TONE or GAP)
//   done     - one-cycle pulse when a pattern completes normally
// Optional feature: define BUZZER_CONTINUOUS_EN to make repeats==0 loop forever.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS = 4,
    parameter int unsigned TICK_DIV     = 100000,
    parameter pattern_t [NUM_PATTERNS-1:0] PATTERNS = DEFAULT_PATTERNS,
    localparam int unsigned MODE_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic              abort,
    output logic              out,
    output logic              busy,
    output logic              done
);

    state_t      state, state_next;
    pattern_t    pat;
    logic [3:0]  rep_cnt;
    logic [11:0] ms_cnt;
    logic [17:0] phase;
    logic        out_q;

    logic        tick;
    logic        entry;      // a state is (re)entered on this edge
    logic        accept;
    logic        tone_exit;
    logic        dur_done;
    logic        last_rep;
    logic [11:0] cur_ms;

    ms_ticker #(.TICK_DIV(TICK_DIV)) u_ticker (
        .clk     (CLK),
        .reset_n (reset_n),
        .clr     (entry || (state == IDLE)),
        .tick    (tick)
    );

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        entry      = 1'b0;
        accept     = 1'b0;
        tone_exit  = 1'b0;
        cur_ms     = (state == GAP) ? pat.off_ms : pat.on_ms;
        // A zero duration ends the state after its single entry cycle.
        dur_done   = (cur_ms == '0) || (tick && (ms_cnt == cur_ms - 12'd1));
`ifdef BUZZER_CONTINUOUS_EN
        last_rep   = (pat.repeats != '0) && (rep_cnt == pat.repeats);
`else
        last_rep   = (rep_cnt == ((pat.repeats == '0) ? 4'd1 : pat.repeats));
`endif
        case (state)
            IDLE: begin
                if (start && (32'(mode) < NUM_PATTERNS)) begin
                    accept     = 1'b1;
                    entry      = 1'b1;
                    state_next = TONE;
                end
            end
            TONE: begin
                if (dur_done) begin
                    tone_exit = 1'b1;
                    entry     = 1'b1;
                    if (last_rep) begin
                        state_next = FINISH;
                    end else if (pat.off_ms != '0) begin
                        state_next = GAP;
                    end else begin
                        state_next = TONE;
                    end
                end
            end
            GAP: begin
                if (dur_done) begin
                    entry      = 1'b1;
                    state_next = TONE;
                end
            end
            FINISH: begin
                entry      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                entry      = 1'b1;
                state_next = IDLE;
            end
        endcase
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
            entry      = 1'b1;
            tone_exit  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            pat     <= '0;
            rep_cnt <= '0;
            ms_cnt  <= '0;
            phase   <= '0;
            out_q   <= 1'b0;
        end else begin
            if (accept) begin
                pat     <= PATTERNS[mode];
                rep_cnt <= 4'd1;
            end else if (tone_exit && (rep_cnt != '1)) begin
                rep_cnt <= rep_cnt + 4'd1;
            end

            if (entry) begin
                ms_cnt <= '0;
                phase  <= '0;
                out_q  <= 1'b0;
            end else begin
                if (tick && (state != IDLE)) begin
                    ms_cnt <= ms_cnt + 12'd1;
                end
                if ((state == TONE) && (pat.on_ms != '0)) begin
                    if (phase == pat.half_period - 18'd1) begin
                        phase <= '0;
                        out_q <= ~out_q;
                    end else begin
                        phase <= phase + 18'd1;
                    end
                end
            end
        end
    end

    assign out  = out_q;
    assign busy = (state == TONE) || (state == GAP);
    assign done = (state == FINISH) && !abort;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: self-checking bench for tone_sequencer.
// A queue holds the expected out/busy/done for every cycle of an accepted
// pattern, built directly from the pattern's timing rules; one compare
// process checks the DUT against it every cycle. Directed scenarios pin the
// model with hand-computed cycle counts, then randomized traffic follows.
module tb_tone_sequencer;
    import tone_pkg::*;

    localparam int unsigned NP = 5;
    localparam int unsigned TD = 10;

    localparam pattern_t [NP-1:0] TB_PATS = {
        pattern_t'{half_period: 18'd2, on_ms: 12'd1, off_ms: 12'd0, repeats: 4'd3},
        pattern_t'{half_period: 18'd5, on_ms: 12'd0, off_ms: 12'd1, repeats: 4'd2},
        pattern_t'{half_period: 18'd4, on_ms: 12'd3, off_ms: 12'd2, repeats: 4'd0},
        pattern_t'{half_period: 18'd2, on_ms: 12'd2, off_ms: 12'd3, repeats: 4'd3},
        pattern_t'{half_period: 18'd3, on_ms: 12'd4, off_ms: 12'd0, repeats: 4'd1}
    };

    logic       CLK;
    logic       reset_n;
    logic       start;
    logic [2:0] mode;
    logic       abort;
    logic       out;
    logic       busy;
    logic       done;

    tone_sequencer #(
        .NUM_PATTERNS (NP),
        .TICK_DIV     (TD),
        .PATTERNS     (TB_PATS)
    ) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .start   (start),
        .mode    (mode),
        .abort   (abort),
        .out     (out),
        .busy    (busy),
        .done    (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic o;
        logic b;
        logic d;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    // Measurements relative to the most recent accepted start (cycle 1 = first busy cycle).
    int unsigned since    = 0;
    int unsigned done_at  = 0;
    int unsigned done_cnt = 0;
    int unsigned busy_cnt = 0;
    int unsigned rise_cnt = 0;
    logic        prev_out = 1'b0;

    function automatic void build(input int unsigned m);
        pattern_t    p;
        int unsigned nrep;
        int unsigned h;
        bit          cont;
        p    = TB_PATS[m];
        nrep = p.repeats;
        h    = p.half_period;
        cont = 1'b0;
        if (nrep == 0) begin
`ifdef BUZZER_CONTINUOUS_EN
            nrep = 60;
            cont = 1'b1;
`else
            nrep = 1;
`endif
        end
        for (int unsigned r = 0; r < nrep; r++) begin
            if (p.on_ms == 0) begin
                exp_q.push_back('{o: 1'b0, b: 1'b1, d: 1'b0});
            end else begin
                for (int unsigned k = 0; k < p.on_ms * TD; k++)
                    exp_q.push_back('{o: ((k / h) % 2) == 1, b: 1'b1, d: 1'b0});
            end
            if ((r != nrep - 1) && (p.off_ms != 0)) begin
                for (int unsigned k = 0; k < p.off_ms * TD; k++)
                    exp_q.push_back('{o: 1'b0, b: 1'b1, d: 1'b0});
            end
        end
        if (!cont) exp_q.push_back('{o: 1'b0, b: 1'b0, d: 1'b1});
    endfunction

    always @(posedge CLK) begin : compare
        exp_t e;
        if (!reset_n) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            if (abort) exp_q.delete();
            else void'(exp_q.pop_front());
        end else if (start && (int'(mode) < NP)) begin
            build(int'(mode));
            since    = 0;
            done_at  = 0;
            done_cnt = 0;
            busy_cnt = 0;
            rise_cnt = 0;
        end
        since++;
        #1;
        e = (exp_q.size() != 0) ? exp_q[0] : exp_t'(3'b000);
        e.d = e.d && !abort;
        vectors++;
        if ({out, busy, done} !== {e.o, e.b, e.d}) begin
            miscompares++;
            $display("FAIL cycle_check t=%0t out/busy/done=%b%b%b required %b%b%b",
                     $time, out, busy, done, e.o, e.b, e.d);
        end
        if (done) begin
            done_cnt++;
            done_at = since;
        end
        if (busy) busy_cnt++;
        if (out && !prev_out) rise_cnt++;
        prev_out = out;
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic step(input logic s, input logic [2:0] m, input logic a, input logic r);
        start   = s;
        mode    = m;
        abort   = a;
        reset_n = r;
        @(negedge CLK);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 1'b1);
    endtask

    initial begin
        for (int unsigned i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b0, 1'b0);
        chk("reset_out", out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        idle(2);

        // Single tone: half=3, 4 ms.
        step(1'b1, 3'd0, 1'b0, 1'b1);
        idle(45);
        chk("single_done_at", done_at, 41);
        chk("single_done_cnt", done_cnt, 1);
        chk("single_busy_cycles", busy_cnt, 40);
        chk("single_rises", rise_cnt, 7);

        // Three bursts separated by gaps.
        step(1'b1, 3'd1, 1'b0, 1'b1);
        idle(125);
        chk("gap_done_at", done_at, 121);
        chk("gap_busy_cycles", busy_cnt, 120);
        chk("gap_rises", rise_cnt, 15);

        // Abort in cycle 80, inside the second gap (cycles 71..100).
        step(1'b1, 3'd1, 1'b0, 1'b1);
        idle(79);
        step(1'b0, 3'd0, 1'b1, 1'b1);
        chk("abort_busy", busy, 0);
        chk("abort_out", out, 0);
        idle(130);
        chk("abort_no_done", done_cnt, 0);
        step(1'b1, 3'd0, 1'b0, 1'b1);
        idle(45);
        chk("after_abort_done_at", done_at, 41);

        // Start while busy is ignored.
        step(1'b1, 3'd0, 1'b0, 1'b1);
        idle(5);
        step(1'b1, 3'd1, 1'b0, 1'b1);
        idle(45);
        chk("busy_start_done_at", done_at, 41);
        chk("busy_start_done_cnt", done_cnt, 1);

        // Out-of-range modes.
        for (int unsigned m = NP; m < 8; m++) begin
            step(1'b1, 3'(m), 1'b0, 1'b1);
            chk("oor_busy", busy, 0);
        end
        idle(3);

        // Reset mid-TONE.
        step(1'b1, 3'd1, 1'b0, 1'b1);
        idle(10);
        step(1'b0, 3'd0, 1'b0, 1'b0);
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        idle(5);

        // repeats == 0.
        step(1'b1, 3'd2, 1'b0, 1'b1);
`ifdef BUZZER_CONTINUOUS_EN
        idle(300);
        chk("cont_no_done", done_cnt, 0);
        chk("cont_busy", busy, 1);
        step(1'b0, 3'd0, 1'b1, 1'b1);
        chk("cont_abort_busy", busy, 0);
`else
        idle(40);
        chk("rep0_done_at", done_at, 31);
        chk("rep0_done_cnt", done_cnt, 1);
`endif
        idle(3);

        // on_ms == 0: 1-cycle silent tones with a 10-cycle gap.
        step(1'b1, 3'd3, 1'b0, 1'b1);
        idle(20);
        chk("on0_done_at", done_at, 13);
        chk("on0_rises", rise_cnt, 0);

        // off_ms == 0: back-to-back tones with phase restart.
        step(1'b1, 3'd4, 1'b0, 1'b1);
        idle(40);
        chk("b2b_done_at", done_at, 31);
        chk("b2b_rises", rise_cnt, 6);

        // Randomized traffic.
        for (int unsigned i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 19) == 0),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 999) != 0));
        end
        step(1'b0, 3'd0, 1'b1, 1'b1);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
